fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_pkg.sv | 30 +++
 rtl/fetch_controller_if.sv | 42 ++++
 rtl/fetch_controller_inst_queue.sv | 63 ++++++
 rtl/fetch_controller.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg
// Shared CPU-front-end definitions used by the fetch controller, its
// instruction queue and the bus interface:
//   - fetch_state_e : request-tracking FSM encoding
//   - fetch_entry_t : one instruction-buffer entry {inst, pc, pred}
//   - XLEN, ENTRY_W : data width and packed entry width
//   - next_seq_pc() : sequential fetch address step
package fetch_controller_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRY_W = 2 * XLEN + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            pred;
  } fetch_entry_t;

  // Sequential fetch step; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] cur);
    return cur + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if
// Bundles every handshake/bus signal of the fetch controller:
//   icache side   : icache_req_valid/addr out, icache_resp_valid/inst in
//   predictor     : pred_pc out, pred_res in (combinational lookup)
//   decoder side  : fetch_ready/inst/pc/pred_out out, issue_ready in,
//                   dec_pc_change_flag/dec_pc_change in
//   RoB side      : flush/flush_pc in
// master = the fetch controller, slave = its environment.
interface fetch_controller_if;
  import fetch_controller_pkg::*;

  logic            icache_req_valid;
  logic [XLEN-1:0] icache_req_addr;
  logic            icache_resp_valid;
  logic [XLEN-1:0] icache_resp_inst;
  logic [XLEN-1:0] pred_pc;
  logic            pred_res;
  logic            fetch_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc;
  logic            pred_out;
  logic            issue_ready;
  logic            dec_pc_change_flag;
  logic [XLEN-1:0] dec_pc_change;
  logic            flush;
  logic [XLEN-1:0] flush_pc;

  modport master (
    output icache_req_valid, icache_req_addr, pred_pc,
           fetch_ready, inst, pc, pred_out,
    input  icache_resp_valid, icache_resp_inst, pred_res, issue_ready,
           dec_pc_change_flag, dec_pc_change, flush, flush_pc
  );

  modport slave (
    input  icache_req_valid, icache_req_addr, pred_pc,
           fetch_ready, inst, pc, pred_out,
    output icache_resp_valid, icache_resp_inst, pred_res, issue_ready,
           dec_pc_change_flag, dec_pc_change, flush, flush_pc
  );

endinterface

// File: rtl/fetch_controller_inst_queue.sv
// inst_queue
// Circular instruction buffer of DEPTH entries (power of two, >= 2).
// Ports:
//   clk_in, rst_in     : clock, synchronous active-high reset
//   push, push_entry   : write an entry at the tail
//   pop                : retire the head entry
//   clear              : empty the buffer (wins over push/pop)
//   full, empty        : occupancy flags
//   head               : current head entry, combinational
module inst_queue
  import fetch_controller_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [PTR_W:0]     count;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic               pop_ok;
  logic               push_ok;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap for free.
  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push_ok) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop_ok)  head_ptr <= head_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + (PTR_W + 1)'(1);
      else if (pop_ok && !push_ok) count <= count - (PTR_W + 1)'(1);
    end
  end

  // Storage is not reset; count alone decides which slots are meaningful.
  always_ff @(posedge clk_in) begin
    if (push_ok && !clear && !rst_in) mem[tail_ptr] <= push_entry;
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign head  = fetch_entry_t'(mem[head_ptr]);

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller
// Instruction fetch front end: issues one icache read at a time at fetch_pc,
// buffers returned instructions with their pc and predictor bit in an
// inst_queue, and handles decoder redirects and RoB flushes.
// Ports:
//   clk_in  : clock
//   rst_in  : synchronous active-high reset (overrides rdy_in and flush)
//   rdy_in  : global ready; all state freezes while low
//   bus     : fetch_controller_if.master (icache, predictor, decoder, RoB)
// Parameter DEPTH: instruction buffer entries (power of two, >= 2).
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  fetch_controller_if.master bus
);

  fetch_state_e    state;
  fetch_state_e    next_state;
  logic            stale_pending;
  logic [XLEN-1:0] fetch_pc;

  logic            q_full;
  logic            q_empty;
  logic            q_clear;
  fetch_entry_t    q_head;
  fetch_entry_t    push_entry;

  logic            resp_seen;
  logic            redirect;
  logic            outstanding;
  logic            can_issue;
  logic            push_fire;
  logic            pop_fire;

  // stale_pending remembers a request that was in flight when reset hit,
  // so its late response is swallowed instead of being taken as new data.
  assign resp_seen   = bus.icache_resp_valid;
  assign redirect    = bus.flush || bus.dec_pc_change_flag;
  assign outstanding = (state != ST_IDLE) || stale_pending;

  assign can_issue = rdy_in && !rst_in && (state == ST_IDLE) && !stale_pending
                     && !q_full && !redirect;
  assign push_fire = rdy_in && !rst_in && (state == ST_WAIT) && resp_seen && !redirect;
  assign pop_fire  = rdy_in && !rst_in && !q_empty && bus.issue_ready;
  assign q_clear   = rdy_in && !rst_in && redirect;

  assign push_entry = '{inst: bus.icache_resp_inst, pc: fetch_pc, pred: bus.pred_res};

  inst_queue #(
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (push_fire),
    .push_entry (push_entry),
    .pop        (pop_fire),
    .clear      (q_clear),
    .full       (q_full),
    .empty      (q_empty),
    .head       (q_head)
  );

  // State register; a reset that lands on an outstanding request arms
  // stale_pending so the next idle cycle turns into a discard.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= ST_IDLE;
      stale_pending <= outstanding && !resp_seen;
    end else if (rdy_in) begin
      state         <= next_state;
      stale_pending <= 1'b0;
    end
  end

  // Fetch pc: flush beats decoder redirect, which beats sequential advance.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_pc <= '0;
    end else if (rdy_in) begin
      if (bus.flush)                   fetch_pc <= bus.flush_pc;
      else if (bus.dec_pc_change_flag) fetch_pc <= bus.dec_pc_change;
      else if (push_fire)              fetch_pc <= next_seq_pc(fetch_pc);
    end
  end

  // Next-state logic. On a redirect any request still in flight must have its
  // response dropped, so we park in DISCARD until it shows up; this also
  // covers a redirect that arrives while already discarding.
  always_comb begin
    next_state = state;
    if (redirect) begin
      next_state = (outstanding && !resp_seen) ? ST_DISCARD : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (stale_pending)  next_state = resp_seen ? ST_IDLE : ST_DISCARD;
          else if (can_issue) next_state = ST_WAIT;
        end
        ST_WAIT:    if (resp_seen) next_state = ST_IDLE;
        ST_DISCARD: if (resp_seen) next_state = ST_IDLE;
        default:    next_state = ST_IDLE;
      endcase
    end
  end

  // Outputs: request pulse for the single IDLE cycle that launches a read,
  // buffer head exposed directly, hidden while reset is asserted.
  always_comb begin
    bus.icache_req_valid = can_issue;
    bus.icache_req_addr  = fetch_pc;
    bus.pred_pc          = fetch_pc;
    bus.fetch_ready      = !q_empty && !rst_in;
    bus.inst             = q_head.inst;
    bus.pc               = q_head.pc;
    bus.pred_out         = q_head.pred;
  end

endmodule
